// File: rtl/vga_sched_pkg.sv
// Shared types and constants for the VGA frame scheduler.
package vga_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ISSUE   = 2'd2,
    RUN     = 2'd3
  } sched_state_e;

  localparam int unsigned DEF_H_RES = 32'd640;
  localparam int unsigned DEF_V_RES = 32'd480;
  localparam int unsigned DEF_BPP   = 32'd2;

  function automatic int unsigned frame_bytes(input int unsigned h_res,
                                              input int unsigned v_res,
                                              input int unsigned bpp);
    return h_res * v_res * bpp;
  endfunction

endpackage

// File: rtl/vga_vsync_edge.sv
// Frame-start detector: registers vsync and flags its falling edge.
module vga_vsync_edge (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic fs
);

  logic vsync_d_r;

  // One-cycle delayed vsync; idles high so a reset with vsync low is not a frame start
  always_ff @(posedge clk) begin
    if (!reset) begin
      vsync_d_r <= 1'b1;
    end else begin
      vsync_d_r <= vsync;
    end
  end

  assign fs = vsync_d_r & ~vsync;

endmodule

// File: rtl/vga_frame_scheduler.sv
// Per-frame MM2S command issue with double buffering and underrun flagging.
// Underrun detection is built only when VGA_SCHED_UNDERRUN_EN is defined.
module vga_frame_scheduler
  import vga_sched_pkg::*;
#(
  parameter int          ADDR_W = 32,
  parameter int          LEN_W  = 23,
  parameter int unsigned H_RES  = DEF_H_RES,
  parameter int unsigned V_RES  = DEF_V_RES,
  parameter int unsigned BPP    = DEF_BPP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] buf0_addr,
  input  logic [ADDR_W-1:0] buf1_addr,
  input  logic              swap_req,
  output logic              swap_done,
  input  logic              vsync,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              dma_done,
  output logic              busy,
  output logic              front_buf,
  output logic [15:0]       frame_cnt,
  output logic              irq,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam int unsigned FRAME_BYTES = frame_bytes(H_RES, V_RES, BPP);
  localparam logic [LEN_W-1:0] FRAME_LEN = FRAME_BYTES[LEN_W-1:0];

`ifdef VGA_SCHED_UNDERRUN_EN
  localparam logic UNDERRUN_EN = 1'b1;
`else
  localparam logic UNDERRUN_EN = 1'b0;
`endif

  sched_state_e      state_r;
  sched_state_e      next_state_s;
  logic              fs_s;
  logic              enter_issue_s;
  logic              frame_done_s;
  logic              underrun_set_s;
  logic              next_front_s;
  logic              swap_pending_r;
  logic              swap_done_r;
  logic              cmd_valid_r;
  logic [ADDR_W-1:0] cmd_addr_r;
  logic [LEN_W-1:0]  cmd_len_r;
  logic              busy_r;
  logic              front_buf_r;
  logic [15:0]       frame_cnt_r;
  logic              irq_r;
  logic              underrun_r;

  vga_vsync_edge u_vsync_edge (
    .clk   (clk),
    .reset (reset),
    .vsync (vsync),
    .fs    (fs_s)
  );

  assign next_front_s = front_buf_r ^ swap_pending_r;

  // Next-state decode plus the per-cycle events that drive the registered outputs
  always_comb begin
    next_state_s   = state_r;
    enter_issue_s  = 1'b0;
    frame_done_s   = 1'b0;
    underrun_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          next_state_s = WAIT_VS;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT_VS: begin
        if (!enable) begin
          next_state_s = IDLE;
        end else if (fs_s) begin
          next_state_s  = ISSUE;
          enter_issue_s = 1'b1;
        end else begin
          next_state_s = WAIT_VS;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          next_state_s = RUN;
        end else begin
          next_state_s = ISSUE;
        end
      end
      RUN: begin
        if (dma_done) begin
          frame_done_s = 1'b1;
          // A frame start landing on completion is consumed as the next frame
          if (enable && fs_s) begin
            next_state_s  = ISSUE;
            enter_issue_s = 1'b1;
          end else if (enable) begin
            next_state_s = WAIT_VS;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_state_s   = RUN;
          underrun_set_s = UNDERRUN_EN & fs_s;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Scheduler state and all registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= IDLE;
      swap_pending_r <= 1'b0;
      swap_done_r    <= 1'b0;
      cmd_valid_r    <= 1'b0;
      cmd_addr_r     <= '0;
      cmd_len_r      <= '0;
      busy_r         <= 1'b0;
      front_buf_r    <= 1'b0;
      frame_cnt_r    <= 16'd0;
      irq_r          <= 1'b0;
      underrun_r     <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      cmd_valid_r <= (next_state_s == ISSUE);
      busy_r      <= (next_state_s == ISSUE) || (next_state_s == RUN);
      swap_done_r <= enter_issue_s & swap_pending_r;
      irq_r       <= frame_done_s;
      if (frame_done_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      // Buffer addresses are sampled only here; a swap_req this cycle waits a frame
      if (enter_issue_s) begin
        front_buf_r    <= next_front_s;
        cmd_addr_r     <= next_front_s ? buf1_addr : buf0_addr;
        cmd_len_r      <= FRAME_LEN;
        swap_pending_r <= swap_req;
      end else begin
        swap_pending_r <= swap_pending_r | swap_req;
      end
      if (underrun_set_s) begin
        underrun_r <= 1'b1;
      end else if (underrun_clr) begin
        underrun_r <= 1'b0;
      end
    end
  end

  assign swap_done = swap_done_r;
  assign cmd_valid = cmd_valid_r;
  assign cmd_addr  = cmd_addr_r;
  assign cmd_len   = cmd_len_r;
  assign busy      = busy_r;
  assign front_buf = front_buf_r;
  assign frame_cnt = frame_cnt_r;
  assign irq       = irq_r;
  assign underrun  = underrun_r;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed self-checking bench for vga_frame_scheduler (default geometry).
module tb_vga_frame_scheduler;

`ifdef VGA_SCHED_UNDERRUN_EN
  localparam logic UR = 1'b1;
`else
  localparam logic UR = 1'b0;
`endif

  localparam logic [31:0] BUF0 = 32'h2000_0000;
  localparam logic [31:0] BUF1 = 32'h1000_0000;
  localparam logic [22:0] FLEN = 23'h096000;

  logic        clk = 1'b0;
  logic        reset, enable, swap_req, vsync, cmd_ready, dma_done, underrun_clr;
  logic [31:0] buf0_addr, buf1_addr;
  logic        swap_done, cmd_valid, busy, front_buf, irq, underrun;
  logic [31:0] cmd_addr;
  logic [22:0] cmd_len;
  logic [15:0] frame_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_frame_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .buf0_addr    (buf0_addr),
    .buf1_addr    (buf1_addr),
    .swap_req     (swap_req),
    .swap_done    (swap_done),
    .vsync        (vsync),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .dma_done     (dma_done),
    .busy         (busy),
    .front_buf    (front_buf),
    .frame_cnt    (frame_cnt),
    .irq          (irq),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_vs();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
  endtask

  task automatic accept();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  task automatic done();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_vec({tag, ".cmd_valid"}, 64'(cmd_valid), 64'd0);
    check_vec({tag, ".cmd_addr"},  64'(cmd_addr),  64'd0);
    check_vec({tag, ".cmd_len"},   64'(cmd_len),   64'd0);
    check_vec({tag, ".busy"},      64'(busy),      64'd0);
    check_vec({tag, ".front_buf"}, 64'(front_buf), 64'd0);
    check_vec({tag, ".swap_done"}, 64'(swap_done), 64'd0);
    check_vec({tag, ".irq"},       64'(irq),       64'd0);
    check_vec({tag, ".underrun"},  64'(underrun),  64'd0);
    check_vec({tag, ".frame_cnt"}, 64'(frame_cnt), 64'd0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; swap_req = 1'b0; vsync = 1'b1;
    cmd_ready = 1'b0; dma_done = 1'b0; underrun_clr = 1'b0;
    buf0_addr = BUF0; buf1_addr = BUF1;
    repeat (3) tick();
    check_reset_state("rst");
    reset = 1'b1;

    // First frame from buf0, command held until accepted
    enable = 1'b1;
    tick();
    pulse_vs();
    check_vec("f1.valid", 64'(cmd_valid), 64'd1);
    check_vec("f1.addr",  64'(cmd_addr),  64'(BUF0));
    check_vec("f1.len",   64'(cmd_len),   64'(FLEN));
    check_vec("f1.busy",  64'(busy),      64'd1);
    check_vec("f1.swap",  64'(swap_done), 64'd0);
    tick(); tick();
    check_vec("f1.hold_valid", 64'(cmd_valid), 64'd1);
    check_vec("f1.hold_addr",  64'(cmd_addr),  64'(BUF0));
    accept();
    check_vec("f1.acc_valid", 64'(cmd_valid), 64'd0);
    check_vec("f1.acc_busy",  64'(busy),      64'd1);
    tick();
    done();
    check_vec("f1.irq",  64'(irq),       64'd1);
    check_vec("f1.cnt",  64'(frame_cnt), 64'd1);
    check_vec("f1.idle", 64'(busy),      64'd0);
    tick();
    check_vec("f1.irq_off", 64'(irq), 64'd0);

    // Swap requested mid-frame takes effect at the next frame start
    pulse_vs();
    accept();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    check_vec("sw.no_early", 64'(swap_done), 64'd0);
    check_vec("sw.front_0",  64'(front_buf), 64'd0);
    done();
    check_vec("sw.cnt2", 64'(frame_cnt), 64'd2);
    tick();
    pulse_vs();
    check_vec("sw.done",  64'(swap_done), 64'd1);
    check_vec("sw.front", 64'(front_buf), 64'd1);
    check_vec("sw.addr",  64'(cmd_addr),  64'(BUF1));
    tick();
    check_vec("sw.pulse", 64'(swap_done), 64'd0);
    accept();
    done();
    check_vec("sw.cnt3", 64'(frame_cnt), 64'd3);

    // Frame start while the DMA is still running
    tick();
    pulse_vs();
    accept();
    tick();
    pulse_vs();
    check_vec("ur.set",    64'(underrun),  64'(UR));
    check_vec("ur.no_cmd", 64'(cmd_valid), 64'd0);
    check_vec("ur.busy",   64'(busy),      64'd1);
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    check_vec("ur.clr", 64'(underrun), 64'd0);
    vsync = 1'b0; underrun_clr = 1'b1; tick(); vsync = 1'b1; underrun_clr = 1'b0;
    check_vec("ur.set_wins", 64'(underrun),  64'(UR));
    check_vec("ur.no_cmd2",  64'(cmd_valid), 64'd0);
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    check_vec("ur.clr2", 64'(underrun), 64'd0);
    done();
    check_vec("ur.cnt4", 64'(frame_cnt), 64'd4);
    check_vec("ur.idle", 64'(busy),      64'd0);

    // Completion coincides with frame start: direct reissue; swap_req then defers
    tick();
    pulse_vs();
    accept();
    tick();
    vsync = 1'b0; dma_done = 1'b1; swap_req = 1'b1;
    tick();
    vsync = 1'b1; dma_done = 1'b0; swap_req = 1'b0;
    check_vec("ri.valid", 64'(cmd_valid), 64'd1);
    check_vec("ri.busy",  64'(busy),      64'd1);
    check_vec("ri.irq",   64'(irq),       64'd1);
    check_vec("ri.cnt5",  64'(frame_cnt), 64'd5);
    check_vec("ri.ur",    64'(underrun),  64'd0);
    check_vec("ri.swap",  64'(swap_done), 64'd0);
    check_vec("ri.addr",  64'(cmd_addr),  64'(BUF1));
    accept();
    done();
    check_vec("ri.cnt6", 64'(frame_cnt), 64'd6);
    tick();

    // Deferred swap applies here; enable drop does not withdraw the command
    pulse_vs();
    check_vec("en.swap",  64'(swap_done), 64'd1);
    check_vec("en.front", 64'(front_buf), 64'd0);
    check_vec("en.addr",  64'(cmd_addr),  64'(BUF0));
    enable = 1'b0;
    tick();
    check_vec("en.hold1", 64'(cmd_valid), 64'd1);
    tick();
    check_vec("en.hold2", 64'(cmd_valid), 64'd1);
    check_vec("en.addr2", 64'(cmd_addr),  64'(BUF0));
    accept();
    check_vec("en.run", 64'(busy), 64'd1);
    done();
    check_vec("en.cnt7", 64'(frame_cnt), 64'd7);
    check_vec("en.idle", 64'(busy),      64'd0);
    tick();
    pulse_vs();
    tick();
    check_vec("en.no_cmd",  64'(cmd_valid), 64'd0);
    check_vec("en.no_busy", 64'(busy),      64'd0);

    // Reset in the middle of a frame
    enable = 1'b1;
    tick();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    pulse_vs();
    check_vec("rr.front", 64'(front_buf), 64'd1);
    accept();
    tick();
    pulse_vs();
    check_vec("rr.ur",   64'(underrun), 64'(UR));
    check_vec("rr.busy", 64'(busy),     64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_reset_state("rr");

    // Back-to-back frames with reissue on every completion
    tick();
    pulse_vs();
    cmd_ready = 1'b1;
    tick();
    for (int i = 0; i < 300; i++) begin
      vsync = 1'b0; dma_done = 1'b1;
      tick();
      vsync = 1'b1; dma_done = 1'b0;
      tick();
    end
    cmd_ready = 1'b0;
    check_vec("bb.cnt",  64'(frame_cnt), 64'd300);
    check_vec("bb.ur",   64'(underrun),  64'd0);
    check_vec("bb.busy", 64'(busy),      64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_frame_scheduler.md
# vga_frame_scheduler

Frame-level controller for the VGA DMA display path. It issues one MM2S DMA command per video frame, timed from the VGA timing generator's vsync. It double-buffers between two frame-buffer base addresses, with CPU-requested swaps applied only at frame boundaries. It also flags underruns, where the DMA has not finished a frame before the next frame start.

## Interface
Parameters:
- ADDR_W, 32, DMA address width
- LEN_W, 23, DMA byte-length field width
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- BPP, 2, bytes per pixel (16-bit rgb)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- enable  in  1  run request from control register
- buf0_addr, buf1_addr  in  ADDR_W  frame-buffer base addresses
- swap_req  in  1  single-cycle pulse: toggle front buffer at next frame start
- swap_done  out  1  single-cycle pulse when a swap is applied
- vsync  in  1  active-low vsync from the VGA timing block
- cmd_valid  out  1  DMA command valid
- cmd_ready  in  1  DMA command accept
- cmd_addr  out  ADDR_W  command base address
- cmd_len  out  LEN_W  command length in bytes
- dma_done  in  1  single-cycle pulse on transfer completion
- busy  out  1  command outstanding (ISSUE or RUN)
- front_buf  out  1  buffer currently scanned out
- frame_cnt  out  16  completed frames, wraps
- irq  out  1  single-cycle pulse per completed frame
- underrun  out  1  sticky underrun flag
- underrun_clr  in  1  clears underrun

## Operation
- Frame start (fs) is the vsync falling edge: vsync_d is high and vsync is low. vsync_d is a one-cycle delayed copy of vsync and resets to 1.
- FRAME_BYTES = H_RES*V_RES*BPP. The default is 614400 (0x96000).
- State machine:
  - IDLE: go to WAIT_VS when enable=1.
  - WAIT_VS: on fs, go to ISSUE. If enable=0, go to IDLE.
  - ISSUE: cmd_valid=1. Go to RUN when cmd_ready=1.
  - RUN: on dma_done, go to WAIT_VS if enable=1, otherwise IDLE. If dma_done and fs occur in the same cycle with enable=1, go directly to ISSUE; that fs is consumed as the next frame start.
- On transition into ISSUE:
  - If swap_pending=1, toggle front_buf, clear swap_pending and pulse swap_done.
  - Then load cmd_addr from the new front buffer's address and load cmd_len=FRAME_BYTES.
  - buf addresses are sampled only at this point.
- swap_pending is set by swap_req in any state. The decision at ISSUE entry uses the registered value, so a swap_req in the same cycle as the ISSUE entry applies to the following frame.
- cmd_valid, cmd_addr and cmd_len stay stable until accepted. Deasserting enable never withdraws a pending or accepted command.
- On dma_done in RUN: frame_cnt increments and irq pulses. dma_done outside RUN is ignored.
- Underrun: fs in RUN without dma_done in the same cycle sets underrun. The state stays in RUN, with no reissue. If set and underrun_clr occur in the same cycle, set wins.

## Timing
- Reset values: cmd_valid=0, cmd_addr=0, cmd_len=0, busy=0, front_buf=0, swap_done=0, irq=0, underrun=0, frame_cnt=0, state IDLE, swap_pending=0.
- All outputs are registered.
- If vsync is first low at cycle n, then at n+1: cmd_valid=1, cmd_addr valid, busy=1, and swap_done pulses if a swap was pending.
- If cmd_ready=1 while cmd_valid=1 at cycle k, cmd_valid=0 at k+1.
- If dma_done at cycle m, then at m+1: irq=1, frame_cnt+1, and busy=0 unless directly reissuing.
- A reset asserted mid-frame returns all state to reset values within one cycle. The DMA must be reset alongside this block.

## Configuration
- VGA_SCHED_UNDERRUN_EN defined: underrun detection as specified.
- VGA_SCHED_UNDERRUN_EN undefined: underrun is tied 0 and underrun_clr is ignored. An fs in RUN is ignored, except when it coincides with dma_done, where it still triggers a direct reissue.

## Structure
- Package vga_sched_pkg holds:
  - the state enum (IDLE, WAIT_VS, ISSUE, RUN)
  - default H_RES/V_RES/BPP
  - FRAME_BYTES as a function of the parameters
- Sub-module vga_vsync_edge: the vsync delay register and falling-edge pulse. Its reset value is 1.
- Everything else lives in one FSM module.

## Test plan
- Reset, enable=1, vsync pulses low, cmd_ready=1 two cycles after cmd_valid → cmd_addr=buf0_addr, cmd_len=0x96000, cmd_valid held stable until accepted; dma_done → irq pulse, frame_cnt=1.
- swap_req mid-frame, buf1_addr=0x1000_0000 → swap_done and front_buf=1 one cycle after next fs; cmd_addr=0x1000_0000.
- Two fs edges before dma_done → underrun=1 and no second command. underrun_clr → underrun=0. The same scenario with the macro undefined → underrun stays 0.
- dma_done in the same cycle as fs → cmd_valid=1 next cycle, no underrun.
- enable=0 while in ISSUE with cmd_ready=0 → cmd_valid held; after accept and dma_done → IDLE, and no further commands on later fs.
- Reset asserted during RUN → all outputs at reset values the next cycle; 65536 frames → frame_cnt wraps to 0.
